fft_load_ctrl: RTL

- Input-side scheduler for the FFT datapath. Accepts a valid/ready stream of complex samples and generates the natural-order sample index.
- Drives the bit-reverse address stage (en/addr/data) so each frame is written into one bank of a ping-pong input RAM.
- Arbitrates the two banks between the loader and the FFT engine: a filled bank is offered to the engine, and the bank is recycled when the engine reports done.

---
 rtl/fft_pkg.sv | 9 +
 rtl/bank_arb.sv | 73 +++++++
 rtl/fft_load_ctrl.sv | 89 ++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared types and default sizes for the FFT input-side scheduler.
package fft_pkg;
  localparam int TOTAL_STAGE = 10;
  localparam int CPLX_WIDTH  = 32;

  typedef logic [CPLX_WIDTH-1:0] cplx_t;

  typedef enum logic [1:0] {FREE, FILL, FULL, BUSY} bank_st_t;
endpackage

// File: rtl/bank_arb.sv
// Ping-pong bank arbiter: tracks both input-RAM banks between the loader
// (write side) and the FFT engine (read side).
module bank_arb
  import fft_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_valid,
  input  logic i_cmpl,
  input  logic i_abort,
  input  logic i_take,
  input  logic i_done,
  output logic o_ready,
  output logic o_frm_valid,
  output logic o_frm_bank,
  output logic o_wr_sel
);

  bank_st_t r_bank [2];
  bank_st_t w_bank_next [2];
  logic     r_wr_sel;
  logic     r_rd_sel;
  logic     w_wr_sel_next;
  logic     w_rd_sel_next;
  logic     w_acc;

  assign o_ready = ~rst & ((r_bank[r_wr_sel] == FREE) || (r_bank[r_wr_sel] == FILL));
  assign w_acc   = i_valid & o_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bank[0] <= FREE;
      r_bank[1] <= FREE;
      r_wr_sel  <= 1'b0;
      r_rd_sel  <= 1'b0;
    end else begin
      r_bank[0] <= w_bank_next[0];
      r_bank[1] <= w_bank_next[1];
      r_wr_sel  <= w_wr_sel_next;
      r_rd_sel  <= w_rd_sel_next;
    end
  end

  // Write-side transitions need FREE/FILL, read-side need FULL/BUSY, so the
  // two branches never collide on the same bank in one cycle.
  always_comb begin
    w_bank_next[0] = r_bank[0];
    w_bank_next[1] = r_bank[1];
    w_wr_sel_next  = r_wr_sel ^ (w_acc & i_cmpl);
    w_rd_sel_next  = r_rd_sel ^ (i_done & (r_bank[r_rd_sel] == BUSY));
    for (int i = 0; i < 2; i++) begin
      if (w_acc && (r_wr_sel == 1'(i))) begin
        if (i_cmpl)
          w_bank_next[i] = FULL;
        else if (i_abort)
          w_bank_next[i] = FREE;
        else if (r_bank[i] == FREE)
          w_bank_next[i] = FILL;
      end
      if (r_rd_sel == 1'(i)) begin
        if ((r_bank[i] == FULL) && i_take)
          w_bank_next[i] = BUSY;
        else if ((r_bank[i] == BUSY) && i_done)
          w_bank_next[i] = FREE;
      end
    end
  end

  assign o_frm_valid = (r_bank[r_rd_sel] == FULL);
  assign o_frm_bank  = r_rd_sel;
  assign o_wr_sel    = r_wr_sel;

endmodule

// File: rtl/fft_load_ctrl.sv
// FFT input loader: counts natural-order sample indices, registers each
// accepted sample toward the bit-reverse stage and flags frame-length errors.
module fft_load_ctrl #(
  parameter int TOTAL_STAGE = fft_pkg::TOTAL_STAGE,
  parameter int CPLX_WIDTH  = fft_pkg::CPLX_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  input  logic [CPLX_WIDTH-1:0]  s_data,
  input  logic                   s_last,
  output logic                   s_ready,
  output logic                   ben,
  output logic [TOTAL_STAGE-1:0] baddr,
  output logic [CPLX_WIDTH-1:0]  bdata,
  output logic                   bbank,
  output logic                   frm_valid,
  output logic                   frm_bank,
  input  logic                   frm_take,
  input  logic                   frm_done,
  output logic                   err_len,
  output logic [15:0]            frm_cnt
);

  logic [TOTAL_STAGE-1:0] r_cnt;
  logic                   r_ben;
  logic [TOTAL_STAGE-1:0] r_baddr;
  logic [CPLX_WIDTH-1:0]  r_bdata;
  logic                   r_bbank;
  logic                   r_err_len;
  logic [15:0]            r_frm_cnt;

  logic w_ready;
  logic w_acc;
  logic w_cmpl;
  logic w_abort;
  logic w_wr_sel;

  assign w_acc   = s_valid & w_ready;
  assign w_cmpl  = (r_cnt == {TOTAL_STAGE{1'b1}});
  assign w_abort = s_last & ~w_cmpl;

  bank_arb u_bank_arb (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (s_valid),
    .i_cmpl      (w_cmpl),
    .i_abort     (w_abort),
    .i_take      (frm_take),
    .i_done      (frm_done),
    .o_ready     (w_ready),
    .o_frm_valid (frm_valid),
    .o_frm_bank  (frm_bank),
    .o_wr_sel    (w_wr_sel)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_ben     <= 1'b0;
      r_baddr   <= '0;
      r_bdata   <= '0;
      r_bbank   <= 1'b0;
      r_err_len <= 1'b0;
      r_frm_cnt <= '0;
    end else begin
      r_ben     <= w_acc;
      // Missing s_last at N-1 and early s_last are both length errors.
      r_err_len <= w_acc & (w_cmpl ? ~s_last : s_last);
      if (w_acc) begin
        r_baddr <= r_cnt;
        r_bdata <= s_data;
        r_bbank <= w_wr_sel;
        r_cnt   <= (w_cmpl | w_abort) ? '0 : r_cnt + 1'b1;
        if (w_cmpl)
          r_frm_cnt <= r_frm_cnt + 16'd1;
      end
    end
  end

  assign s_ready = w_ready;
  assign ben     = r_ben;
  assign baddr   = r_baddr;
  assign bdata   = r_bdata;
  assign bbank   = r_bbank;
  assign err_len = r_err_len;
  assign frm_cnt = r_frm_cnt;

endmodule
